// File: rtl/wheel_speed_sampler_pkg.sv
// Shared constants and FSM state type for the wheel-speed sampler.
package wheel_speed_sampler_pkg;
  localparam int IDX_W   = 5;
  localparam int IDX_MAX = (1 << IDX_W) - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } state_e;
endpackage

// File: rtl/wheel_speed_sampler_if.sv
// Sensor-side inputs and ROM-side outputs of the wheel-speed sampler.
interface wheel_speed_sampler_if;
  import wheel_speed_sampler_pkg::*;

  logic             pulse_in;
  logic             enable;
  logic [IDX_W-1:0] speed_idx;
  logic             speed_valid;
  logic             overflow;

  modport master (
    output pulse_in, enable,
    input  speed_idx, speed_valid, overflow
  );

  modport slave (
    input  pulse_in, enable,
    output speed_idx, speed_valid, overflow
  );
endinterface

// File: rtl/wheel_speed_sampler_pulse_sync_edge.sv
// Metastability synchronizer for the raw sensor pulse followed by a rising-edge detector.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
endmodule

// File: rtl/wheel_speed_sampler.sv
// Counts wheel-sensor edges per gate window and presents the saturated count as a ROM index.
module wheel_speed_sampler
  import wheel_speed_sampler_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wheel_speed_sampler_if.slave  bus
);
  localparam int            GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic             sat_q, sat_d, sat_nx;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             rise, run, term, at_max;

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.pulse_in),
    .rise     (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A completed window and an abort both land in IDLE when enable is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable)  state_d = SAMPLE;
      SAMPLE:  if (!bus.enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    term = (state_q == SAMPLE) && (gate_q == GATE_LAST);
    run  = (state_q == SAMPLE) && bus.enable && !term;
  end

  assign at_max = (cnt_q == IDX_W'(IDX_MAX));
  assign cnt_nx = (rise && !at_max) ? cnt_q + IDX_W'(1) : cnt_q;
  assign sat_nx = sat_q | (rise & at_max);

  // Terminal cycle publishes regardless of enable; anything else not running clears.
  always_comb begin
    gate_d = '0;
    cnt_d  = '0;
    sat_d  = 1'b0;
    idx_d  = idx_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    if (term) begin
      idx_d = cnt_nx;
      ovf_d = sat_nx;
      vld_d = 1'b1;
    end else if (run) begin
      gate_d = gate_q + GW'(1);
      cnt_d  = cnt_nx;
      sat_d  = sat_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      gate_q <= gate_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      idx_q  <= idx_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.speed_idx   = idx_q;
  assign bus.speed_valid = vld_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: doc/wheel_speed_sampler.md
Name: wheel_speed_sampler

Overview:
Front-end measurement stage that drives the 5-bit address of the cruise-control lookup ROM.
- Counts rising edges of the asynchronous wheel-sensor pulse over a fixed gate window.
- Saturates the count to 5 bits and presents it as the ROM input index.
- Strobes a valid flag once per window so downstream logic knows when a fresh index has been applied.

Parameters:
GATE_CYCLES, 1000, window length in clk cycles (legal range 2..65535)
IDX_W, 5, output index width; saturation value is 2^IDX_W-1 = 31
SYNC_STAGES, 2, flop count of the input synchronizer (legal range 2 or more)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
pulse_in  input  1  raw wheel-sensor pulse, asynchronous to clk
enable  input  1  sampling enable; low holds the block idle
speed_idx  output  IDX_W  last completed window's saturated edge count; connects to ROM in
speed_valid  output  1  one-cycle strobe, high in the cycle speed_idx updates
overflow  output  1  high when the last completed window saturated; updates with speed_idx

Behaviour:
Clock and reset
- One clock, clk; reset is asynchronous and active-low on rst_n.
- rst_n low, from any state including mid-window: immediately clears speed_idx=0, speed_valid=0, overflow=0, synchronizer flops=0, edge-detect flop=0, gate counter=0, pulse counter=0, FSM=IDLE.

Input path
- pulse_in passes through SYNC_STAGES flops, then a one-flop edge detector: edge = sync & ~sync_d.
- An edge is seen SYNC_STAGES+1 cycles after the pulse_in rise.
- pulse_in high or low widths shorter than 2 clk cycles are not guaranteed to be counted.

FSM states: IDLE, SAMPLE
- IDLE: counters held at 0, speed_valid=0, speed_idx and overflow hold their values. enable=1 -> SAMPLE on the next edge.
- SAMPLE: the gate counter increments 0..GATE_CYCLES-1. Each edge increments the pulse counter, saturating at 31; a saturated edge sets an internal sat flag.
- Terminal cycle (gate counter = GATE_CYCLES-1), registered on the next edge:
  - speed_idx <= pulse count, including an edge detected in the terminal cycle itself;
  - overflow <= sat;
  - speed_valid <= 1 for exactly one cycle;
  - gate counter, pulse counter and sat clear to 0;
  - stay in SAMPLE if enable=1, else go to IDLE.
- Window length is exactly GATE_CYCLES cycles. Windows are back-to-back with no dead cycle; an edge in the first cycle of the new window counts toward the new window.
- enable low mid-window: abort, go to IDLE next cycle, discard the partial count, no speed_valid pulse, outputs hold.
- enable re-asserted: a fresh window starts from count 0.

Arithmetic
- Gate counter width is clog2(GATE_CYCLES).
- Pulse counter is IDX_W bits with saturating increment; it never wraps.
- overflow is set even if the true count is exactly 32.

Latency
- speed_idx and speed_valid change together, 1 cycle after the terminal cycle.
- The ROM output is combinational from speed_idx.

Decomposition:
- Shared package holds:
  - IDX_W and the derived constant IDX_MAX = 2^IDX_W-1;
  - the FSM state typedef {IDLE, SAMPLE}.
- One sub-module: pulse_sync_edge. It contains the SYNC_STAGES synchronizer and the edge-detect flop, with ports clk, rst_n, async_in, rise.
- Counters, FSM and output registers stay in wheel_speed_sampler.

Test Plan:
- GATE_CYCLES=100, enable=1, pulse_in period 10 cycles (5 high/5 low), steady state -> speed_valid pulses every 100 cycles; speed_idx=10, overflow=0.
- Same setup with pulse period 4 cycles (25 edges/window) -> speed_idx=25, overflow=0; then period 2 cycles (50 edges/window) -> speed_idx=31, overflow=1.
- Single pulse timed so that its edge is detected in the terminal cycle of a window -> that window reports speed_idx=1; the next window reports 0 if no further pulses arrive.
- enable dropped at window cycle 50 with 7 edges counted -> no speed_valid, speed_idx keeps the previous value. enable raised again -> the first valid comes 101 cycles later with a count taken from a fresh window only.
- rst_n asserted asynchronously between clk edges mid-window, with speed_idx=10 -> speed_idx, overflow and speed_valid go to 0 immediately. After release with enable=1, the first speed_valid comes no earlier than 101 cycles.
- pulse_in held high throughout, then held low throughout -> speed_idx=0 after each window, overflow=0, with no spurious edge counted at enable.
